// File: rtl/romload_sdram_writer_if.sv
// Loader write port between romload_sdram_writer (master) and the SDRAM controller (slave).
// One request is outstanding at a time; mem_ready is a one-cycle accept pulse.
interface romload_sdram_writer_if;
  logic        mem_wr;
  logic [22:0] mem_addr;
  logic [15:0] mem_din;
  logic [1:0]  mem_ds;
  logic        mem_ready;

  modport master (output mem_wr, mem_addr, mem_din, mem_ds, input mem_ready);
  modport slave  (input mem_wr, mem_addr, mem_din, mem_ds, output mem_ready);
endinterface

// File: rtl/romload_sdram_writer.sv
// Packs the iosys ROM-loading byte stream into 16-bit little-endian SDRAM writes via a small FIFO.
// Optional feature macro: ROMLOAD_CHECKSUM_EN adds a 16-bit byte-sum output for each SDRAM session.
module romload_sdram_writer #(
  parameter logic [22:0] ROM_BASE   = 23'h000000,
  parameter logic [22:0] CRAM_BASE  = 23'h700000,
  parameter logic [22:0] BIOS_BASE  = 23'h600000,
  parameter int          FIFO_DEPTH = 4
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic [2:0]                    rom_loading,
  input  logic [7:0]                    rom_do,
  input  logic                          rom_do_valid,
  romload_sdram_writer_if.master        mem,
  output logic                          busy,
  output logic                          load_done,
  output logic [22:0]                   byte_count,
  output logic                          overflow,
  output logic [63:0]                   cfg_data
`ifdef ROMLOAD_CHECKSUM_EN
  ,
  output logic [15:0]                   checksum
`endif
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;

  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_FLUSH} state_t;

  typedef struct packed {
    logic [22:0] addr;
    logic [15:0] din;
    logic [1:0]  ds;
  } wr_entry_t;

  state_t      state_q, state_d;
  logic [2:0]  mode_q;
  logic [22:0] base_q;
  logic [22:0] offset_q;
  logic        pending_q;
  logic [7:0]  pending_byte_q;
  logic        cfg_active_q;

  wr_entry_t        fifo_mem [FIFO_DEPTH];
  logic [PTR_W-1:0] rd_ptr_q, wr_ptr_q;
  logic [CNT_W-1:0] fifo_count_q;

  logic [2:0]  mode_in;
  logic        sdram_mode;
  logic [22:0] base_sel;
  logic [22:0] word_addr;
  logic        fifo_full;
  logic        mem_wr_int;
  logic        pop;
  logic        push;
  logic        push_ok;
  logic        push_drop;
  logic        flush_done;
  logic        flush_drop;
  wr_entry_t   push_entry;
  wr_entry_t   head;
  logic [22:0] cfg_cnt;
  logic [63:0] cfg_next;

  // Unsupported modes 5-7 behave exactly like idle.
  assign mode_in    = (rom_loading > 3'd4) ? 3'd0 : rom_loading;
  assign sdram_mode = (mode_in == 3'd1) || (mode_in == 3'd2) || (mode_in == 3'd4);

  always_comb begin
    case (mode_in)
      3'd1:    base_sel = ROM_BASE;
      3'd2:    base_sel = CRAM_BASE;
      default: base_sel = BIOS_BASE;
    endcase
  end

  // Even address of the pair containing the current offset; wraps mod 2^23.
  assign word_addr  = base_q + {offset_q[22:1], 1'b0};
  assign fifo_full  = (fifo_count_q == CNT_W'(FIFO_DEPTH));
  assign mem_wr_int = (fifo_count_q != '0);
  assign pop        = mem_wr_int && mem.mem_ready;
  assign push_ok    = push && (!fifo_full || pop);
  assign push_drop  = push && !push_ok && (state_q == S_LOAD);

  // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latches).
  always_comb begin
    state_d    = state_q;
    push       = 1'b0;
    push_entry = '0;
    flush_done = 1'b0;
    flush_drop = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (sdram_mode) state_d = S_LOAD;
      end
      S_LOAD: begin
        if (rom_do_valid && offset_q[0]) begin
          push       = 1'b1;
          push_entry = '{addr: word_addr, din: {rom_do, pending_byte_q}, ds: 2'b11};
        end
        if (mode_in != mode_q) state_d = S_FLUSH;
      end
      S_FLUSH: begin
        flush_drop = rom_do_valid;
        if (pending_q) begin
          push       = 1'b1;
          push_entry = '{addr: word_addr, din: {8'h00, pending_byte_q}, ds: 2'b01};
        end else if ((fifo_count_q == '0) || ((fifo_count_q == CNT_W'(1)) && pop)) begin
          state_d    = S_IDLE;
          flush_done = 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Config capture: the first mode-3 cycle restarts from an empty register.
  always_comb begin
    cfg_cnt  = cfg_active_q ? byte_count : '0;
    cfg_next = cfg_active_q ? cfg_data : '0;
    if (rom_do_valid && (cfg_cnt < 23'd8)) cfg_next[{cfg_cnt[2:0], 3'b000} +: 8] = rom_do;
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q        <= S_IDLE;
      mode_q         <= '0;
      base_q         <= '0;
      offset_q       <= '0;
      pending_q      <= 1'b0;
      pending_byte_q <= '0;
      cfg_active_q   <= 1'b0;
      byte_count     <= '0;
      overflow       <= 1'b0;
      cfg_data       <= '0;
      load_done      <= 1'b0;
`ifdef ROMLOAD_CHECKSUM_EN
      checksum       <= '0;
`endif
    end else begin
      state_q      <= state_d;
      load_done    <= flush_done;
      cfg_active_q <= (state_q == S_IDLE) && (mode_in == 3'd3);
      if (push_drop || flush_drop) overflow <= 1'b1;
      case (state_q)
        S_IDLE: begin
          if (sdram_mode) begin
            mode_q     <= mode_in;
            base_q     <= base_sel;
            offset_q   <= '0;
            byte_count <= '0;
            pending_q  <= 1'b0;
`ifdef ROMLOAD_CHECKSUM_EN
            checksum   <= '0;
`endif
          end else if (mode_in == 3'd3) begin
            cfg_data   <= cfg_next;
            byte_count <= cfg_cnt + 23'(rom_do_valid);
          end
        end
        S_LOAD: begin
          if (rom_do_valid) begin
            offset_q   <= offset_q + 23'd1;
            byte_count <= byte_count + 23'd1;
            pending_q  <= !offset_q[0];
            if (!offset_q[0]) pending_byte_q <= rom_do;
`ifdef ROMLOAD_CHECKSUM_EN
            // A dropped word also removes its already-summed low byte.
            checksum <= push_drop ? checksum - {8'h00, pending_byte_q}
                                  : checksum + {8'h00, rom_do};
`endif
          end
        end
        S_FLUSH: begin
          if (pending_q && push_ok) pending_q <= 1'b0;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rd_ptr_q     <= '0;
      wr_ptr_q     <= '0;
      fifo_count_q <= '0;
    end else begin
      if (push_ok) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
      if (pop)     rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      fifo_count_q <= fifo_count_q + CNT_W'(push_ok) - CNT_W'(pop);
    end
  end

  // NOTE: FIFO storage is not reset; entries are only visible through the occupancy-gated outputs.
  always_ff @(posedge clk) begin
    if (push_ok) fifo_mem[wr_ptr_q] <= push_entry;
  end

  assign head         = fifo_mem[rd_ptr_q];
  assign mem.mem_wr   = mem_wr_int;
  assign mem.mem_addr = mem_wr_int ? head.addr : '0;
  assign mem.mem_din  = mem_wr_int ? head.din  : '0;
  assign mem.mem_ds   = mem_wr_int ? head.ds   : '0;
  assign busy         = (state_q != S_IDLE);

endmodule

// File: tb/tb_romload_sdram_writer.sv
// Directed self-checking bench for romload_sdram_writer with a delayed-ready SDRAM responder.
module tb_romload_sdram_writer;

  logic        clk = 1'b0;
  logic        reset;
  logic [2:0]  rom_loading;
  logic [7:0]  rom_do;
  logic        rom_do_valid;
  logic        busy;
  logic        load_done;
  logic [22:0] byte_count;
  logic        overflow;
  logic [63:0] cfg_data;
`ifdef ROMLOAD_CHECKSUM_EN
  logic [15:0] checksum;
`endif

  romload_sdram_writer_if ifc ();

  romload_sdram_writer dut (
    .clk          (clk),
    .reset        (reset),
    .rom_loading  (rom_loading),
    .rom_do       (rom_do),
    .rom_do_valid (rom_do_valid),
    .mem          (ifc.master),
    .busy         (busy),
    .load_done    (load_done),
    .byte_count   (byte_count),
    .overflow     (overflow),
    .cfg_data     (cfg_data)
`ifdef ROMLOAD_CHECKSUM_EN
    ,
    .checksum     (checksum)
`endif
  );

  always #5 clk = ~clk;

  int n_cmp  = 0;
  int n_fail = 0;

  // Responder and monitor state.
  logic        resp_en    = 1'b0;
  int          resp_delay = 2;
  int          done_cnt   = 0;
  int          unstable   = 0;
  logic        wr_seen    = 1'b0;
  logic [22:0] q_addr[$];
  logic [15:0] q_din[$];
  logic [1:0]  q_ds[$];

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n = 1);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic send(input logic [7:0] b);
    rom_do       = b;
    rom_do_valid = 1'b1;
    tick();
    rom_do_valid = 1'b0;
  endtask

  task automatic wait_done(input string tag, input int start);
    int k;
    k = 0;
    while (done_cnt == start && k < 60) begin
      tick();
      k++;
    end
    chk(tag, 64'(done_cnt - start), 64'd1);
  endtask

  task automatic chk_write(input string tag, input int idx, input logic [22:0] a,
                           input logic [15:0] d, input logic [1:0] s);
    if (idx < q_addr.size()) begin
      chk({tag, "_addr"}, 64'(q_addr[idx]), 64'(a));
      chk({tag, "_din"},  64'(q_din[idx]),  64'(d));
      chk({tag, "_ds"},   64'(q_ds[idx]),   64'(s));
    end else begin
      chk({tag, "_present"}, 64'(q_addr.size()), 64'(idx + 1));
    end
  endtask

  task automatic clear_log();
    q_addr.delete();
    q_din.delete();
    q_ds.delete();
  endtask

  // Memory responder: one-cycle ready pulse resp_delay steps after a request is seen.
  initial begin
    int wait_cnt;
    wait_cnt      = 0;
    ifc.mem_ready = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      if (ifc.mem_ready) begin
        ifc.mem_ready = 1'b0;
        wait_cnt      = 0;
      end else if (resp_en && ifc.mem_wr) begin
        wait_cnt++;
        if (wait_cnt >= resp_delay) ifc.mem_ready = 1'b1;
      end else begin
        wait_cnt = 0;
      end
    end
  end

  // Monitor on the inactive edge: accepted writes, load_done pulses, request stability.
  initial begin
    logic        hold;
    logic [40:0] prev;
    hold = 1'b0;
    prev = '0;
    forever begin
      @(negedge clk);
      if (ifc.mem_wr) wr_seen = 1'b1;
      if (ifc.mem_wr && ifc.mem_ready) begin
        q_addr.push_back(ifc.mem_addr);
        q_din.push_back(ifc.mem_din);
        q_ds.push_back(ifc.mem_ds);
      end
      if (load_done) done_cnt++;
      if (hold && ifc.mem_wr && ({ifc.mem_addr, ifc.mem_din, ifc.mem_ds} != prev)) unstable++;
      hold = ifc.mem_wr && !ifc.mem_ready;
      prev = {ifc.mem_addr, ifc.mem_din, ifc.mem_ds};
    end
  end

  initial begin
    int d0;
    reset        = 1'b1;
    rom_loading  = 3'd0;
    rom_do       = 8'h00;
    rom_do_valid = 1'b0;
    tick(3);

    // Reset state.
    chk("rst_mem_wr", 64'(ifc.mem_wr), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_overflow", 64'(overflow), 64'd0);
    chk("rst_byte_count", 64'(byte_count), 64'd0);
    chk("rst_cfg_data", cfg_data, 64'd0);
    chk("rst_load_done", 64'(load_done), 64'd0);
    reset = 1'b0;
    tick(2);

    // 1: ROM session, widely spaced bytes, ready two steps after request.
    resp_en     = 1'b1;
    resp_delay  = 2;
    d0          = done_cnt;
    clear_log();
    rom_loading = 3'd1;
    tick(2);
    chk("t1_busy", 64'(busy), 64'd1);
    send(8'h11); tick(11);
    send(8'h22); tick(11);
    send(8'h33); tick(11);
    send(8'h44); tick(11);
    rom_loading = 3'd0;
    wait_done("t1_done", d0);
    tick(3);
    chk("t1_nwrites", 64'(q_addr.size()), 64'd2);
    chk_write("t1_w0", 0, 23'h000000, 16'h2211, 2'b11);
    chk_write("t1_w1", 1, 23'h000002, 16'h4433, 2'b11);
    chk("t1_done_once", 64'(done_cnt - d0), 64'd1);
    chk("t1_byte_count", 64'(byte_count), 64'd4);
    chk("t1_busy_end", 64'(busy), 64'd0);

    // 2: cart RAM session with an odd byte count.
    d0 = done_cnt;
    clear_log();
    rom_loading = 3'd2;
    tick(2);
    send(8'hAA);
    send(8'hBB);
    send(8'hCC);
    tick(5);
    rom_loading = 3'd0;
    wait_done("t2_done", d0);
    tick(3);
    chk("t2_nwrites", 64'(q_addr.size()), 64'd2);
    chk_write("t2_w0", 0, 23'h700000, 16'hBBAA, 2'b11);
    chk_write("t2_w1", 1, 23'h700002, 16'h00CC, 2'b01);
    chk("t2_byte_count", 64'(byte_count), 64'd3);
`ifdef ROMLOAD_CHECKSUM_EN
    chk("t2_checksum", 64'(checksum), 64'h0231);
`endif

    // 3: configuration bytes, only the first eight are kept.
    d0 = done_cnt;
    clear_log();
    wr_seen     = 1'b0;
    rom_loading = 3'd3;
    tick(1);
    for (int i = 1; i <= 10; i++) send(8'(i));
    tick(2);
    chk("t3_cfg_data", cfg_data, 64'h0807060504030201);
    chk("t3_byte_count", 64'(byte_count), 64'd10);
    chk("t3_no_mem_wr", 64'(wr_seen), 64'd0);
    chk("t3_no_done", 64'(done_cnt - d0), 64'd0);
    chk("t3_busy", 64'(busy), 64'd0);
    rom_loading = 3'd0;
    tick(2);

    // 4: stalled memory, FIFO fills and the fifth word is dropped.
    resp_en     = 1'b0;
    d0          = done_cnt;
    clear_log();
    rom_loading = 3'd1;
    tick(2);
    unstable    = 0;
    chk("t4_overflow_pre", 64'(overflow), 64'd0);
    for (int i = 1; i <= 10; i++) send(8'(i));
    tick(3);
    chk("t4_overflow", 64'(overflow), 64'd1);
    chk("t4_mem_wr", 64'(ifc.mem_wr), 64'd1);
    chk("t4_head_addr", 64'(ifc.mem_addr), 64'h000000);
    chk("t4_head_din", 64'(ifc.mem_din), 64'h0201);
    chk("t4_head_ds", 64'(ifc.mem_ds), 64'd3);
    chk("t4_stable", 64'(unstable), 64'd0);
    chk("t4_byte_count", 64'(byte_count), 64'd10);
    resp_en     = 1'b1;
    rom_loading = 3'd0;
    wait_done("t4_done", d0);
    tick(3);
    chk("t4_nwrites", 64'(q_addr.size()), 64'd4);
    chk_write("t4_w3", 3, 23'h000006, 16'h0807, 2'b11);
`ifdef ROMLOAD_CHECKSUM_EN
    chk("t4_checksum", 64'(checksum), 64'h0024);
`endif

    // 5: BIOS session switched straight to ROM with a byte pending.
    d0 = done_cnt;
    clear_log();
    rom_loading = 3'd4;
    tick(2);
    send(8'hA1);
    send(8'hA2);
    send(8'hA3);
    tick(6);
    rom_loading = 3'd1;
    wait_done("t5_done", d0);
    tick(1);
    chk("t5_nwrites", 64'(q_addr.size()), 64'd2);
    chk_write("t5_w0", 0, 23'h600000, 16'hA2A1, 2'b11);
    chk_write("t5_w1", 1, 23'h600002, 16'h00A3, 2'b01);
    chk("t5_new_busy", 64'(busy), 64'd1);
    clear_log();
    send(8'hB1);
    send(8'hB2);
    tick(6);
    chk("t5_new_nwrites", 64'(q_addr.size()), 64'd1);
    chk_write("t5_new_w0", 0, 23'h000000, 16'hB2B1, 2'b11);
    chk("t5_new_byte_count", 64'(byte_count), 64'd2);

    // 6: reset while a write is outstanding.
    resp_en = 1'b0;
    d0      = done_cnt;
    send(8'hC1);
    send(8'hC2);
    tick(2);
    chk("t6_mem_wr_pre", 64'(ifc.mem_wr), 64'd1);
    reset       = 1'b1;
    rom_loading = 3'd0;
    tick(1);
    chk("t6_mem_wr", 64'(ifc.mem_wr), 64'd0);
    chk("t6_busy", 64'(busy), 64'd0);
    chk("t6_overflow", 64'(overflow), 64'd0);
    chk("t6_load_done", 64'(load_done), 64'd0);
    reset = 1'b0;
    tick(5);
    chk("t6_no_done", 64'(done_cnt - d0), 64'd0);
    chk("t6_mem_wr_after", 64'(ifc.mem_wr), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
